// File: rtl/my2_div_ctrl.sv
// Repeated-subtraction divider controller for the my2_fsm_dp datapath.
// Optional MY2_DIV_ZERO_DETECT_EN adds a b_zero input that short-circuits to an error completion.
module my2_div_ctrl #(
   parameter int QW       = 32,
   parameter int MAX_ITER = 65535
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          start,
`ifdef MY2_DIV_ZERO_DETECT_EN
   input  logic          b_zero,
`endif
   input  logic          x,
   output logic          s,
   output logic          we,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [QW-1:0] quotient
);

   typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

   localparam logic [QW-1:0] Q_ONE  = {{(QW-1){1'b0}}, 1'b1};
   localparam logic [QW-1:0] Q_LAST = QW'(MAX_ITER - 1);

   state_t state;
   logic   zero_req;

`ifdef MY2_DIV_ZERO_DETECT_EN
   assign zero_req = b_zero;
`else
   assign zero_req = 1'b0;
`endif

   // x is sampled half a cycle after the datapath's negedge write, so it is
   // stable across the ITER cycle and drives the commit directly.
   assign we = (state == LOAD) | ((state == ITER) & ~x);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         s        <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         quotient <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  quotient <= '0;
                  err      <= 1'b0;
                  if (zero_req) begin
                     state <= DONE;
                     err   <= 1'b1;
                     done  <= 1'b1;
                     s     <= 1'b1;
                  end else begin
                     state <= LOAD;
                     busy  <= 1'b1;
                  end
               end
            end
            LOAD: begin
               state <= ITER;
               s     <= 1'b1;
            end
            ITER: begin
               if (!x) begin
                  quotient <= quotient + Q_ONE;
                  // Iteration cap doubles as the divide-by-zero escape.
                  if (quotient == Q_LAST) begin
                     err   <= 1'b1;
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end else begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               s     <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_my2_div_ctrl.sv
// Directed bench for my2_div_ctrl with behavioural negedge datapath models.
module tb_my2_div_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   int          n_checks = 0;
   int          n_fail   = 0;

   // main instance (default parameters)
   logic        start = 1'b0, b_zero = 1'b0, x, s, we, busy, done, err;
   logic [31:0] quotient, a_in = '0, b_in = '0, temp;
   // small instance for the iteration cap
   logic        start8 = 1'b0, b_zero8 = 1'b0, x8, s8, we8, busy8, done8, err8;
   logic [3:0]  quotient8;
   logic [31:0] a8 = '0, b8 = '0, temp8;

   always #5 CLK = ~CLK;

   my2_div_ctrl dut (
      .CLK(CLK), .RST(RST), .start(start),
`ifdef MY2_DIV_ZERO_DETECT_EN
      .b_zero(b_zero),
`endif
      .x(x), .s(s), .we(we), .busy(busy), .done(done), .err(err), .quotient(quotient)
   );

   my2_div_ctrl #(.QW(4), .MAX_ITER(8)) dut8 (
      .CLK(CLK), .RST(RST), .start(start8),
`ifdef MY2_DIV_ZERO_DETECT_EN
      .b_zero(b_zero8),
`endif
      .x(x8), .s(s8), .we(we8), .busy(busy8), .done(done8), .err(err8), .quotient(quotient8)
   );

   // datapath: register written on negedge, sign flag presented to the FSM on posedge
   always @(negedge CLK) if (we)  temp  <= s  ? temp  + b_in : a_in;
   always @(negedge CLK) if (we8) temp8 <= s8 ? temp8 + b8   : a8;
   always @(posedge CLK) x  <= $signed(temp  + b_in) < 0;
   always @(posedge CLK) x8 <= $signed(temp8 + b8)   < 0;

   // Launch one division from an idle cycle; returns the cycle done was seen and a we-per-cycle map.
   task automatic launch(input bit sel, input logic [31:0] a, input logic [31:0] b,
                         output int done_cyc, output logic [63:0] we_bits);
      done_cyc = 0;
      we_bits  = '0;
      @(posedge CLK); #1;
      if (sel) begin a8 = a; b8 = b; start8 = 1'b1; end
      else     begin a_in = a; b_in = b; start = 1'b1; end
      @(posedge CLK); #1;
      start = 1'b0; start8 = 1'b0;
      for (int c = 1; c < 64; c++) begin
         if (sel ? we8 : we) we_bits[c] = 1'b1;
         if (sel ? done8 : done) begin done_cyc = c; break; end
         @(posedge CLK); #1;
      end
   endtask

   task automatic test_reset;
      #3;
      n_checks++; if ({s, we, busy, done, err} !== 5'b0) begin n_fail++; $display("FAIL reset_outs got %b want 00000", {s, we, busy, done, err}); end
      n_checks++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL reset_q got %0d want 0", quotient); end
      n_checks++; if ({s8, we8, busy8, done8, err8, quotient8} !== 9'b0) begin n_fail++; $display("FAIL reset_dut8 got %b want 0", {s8, we8, busy8, done8, err8, quotient8}); end
      @(posedge CLK); #2; RST = 1'b0;
      @(posedge CLK); #1;
   endtask

   task automatic test_div_basic;
      int dc; logic [63:0] wb;
      launch(1'b0, 32'd17, 32'hFFFF_FFFB, dc, wb);
      n_checks++; if (dc !== 6) begin n_fail++; $display("FAIL div17_done_cyc got %0d want 6", dc); end
      n_checks++; if (wb !== 64'h1E) begin n_fail++; $display("FAIL div17_we got %h want 1e", wb); end
      n_checks++; if (quotient !== 32'd3) begin n_fail++; $display("FAIL div17_q got %0d want 3", quotient); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL div17_err got %b want 0", err); end
      n_checks++; if (temp !== 32'd2) begin n_fail++; $display("FAIL div17_rem got %0d want 2", temp); end
      @(posedge CLK); #1;
      n_checks++; if ({done, busy, quotient} !== {2'b00, 32'd3}) begin n_fail++; $display("FAIL div17_hold got done=%b busy=%b q=%0d want 0 0 3", done, busy, quotient); end
   endtask

   task automatic test_exact;
      int dc; logic [63:0] wb;
      launch(1'b0, 32'd15, 32'hFFFF_FFFB, dc, wb);
      n_checks++; if (dc !== 6) begin n_fail++; $display("FAIL exact_done_cyc got %0d want 6", dc); end
      n_checks++; if (quotient !== 32'd3 || temp !== 32'd0) begin n_fail++; $display("FAIL exact_q_rem got %0d/%0d want 3/0", quotient, temp); end
   endtask

   task automatic test_small_dividend;
      int dc; logic [63:0] wb;
      launch(1'b0, 32'd4, 32'hFFFF_FFFB, dc, wb);
      n_checks++; if (dc !== 3) begin n_fail++; $display("FAIL small_done_cyc got %0d want 3", dc); end
      n_checks++; if (wb !== 64'h2) begin n_fail++; $display("FAIL small_we got %h want 2", wb); end
      n_checks++; if (quotient !== 32'd0 || temp !== 32'd4 || err !== 1'b0) begin n_fail++; $display("FAIL small_res got q=%0d rem=%0d err=%b want 0 4 0", quotient, temp, err); end
   endtask

   task automatic test_max_iter;
      int dc; logic [63:0] wb;
      launch(1'b1, 32'd9, 32'd0, dc, wb);
      n_checks++; if (dc !== 10) begin n_fail++; $display("FAIL maxit_done_cyc got %0d want 10", dc); end
      n_checks++; if (wb !== 64'h3FE) begin n_fail++; $display("FAIL maxit_we got %h want 3fe", wb); end
      n_checks++; if (quotient8 !== 4'd8 || err8 !== 1'b1) begin n_fail++; $display("FAIL maxit_res got q=%0d err=%b want 8 1", quotient8, err8); end
      launch(1'b1, 32'd17, 32'hFFFF_FFFB, dc, wb);
      n_checks++; if (quotient8 !== 4'd3 || err8 !== 1'b0 || dc !== 6) begin n_fail++; $display("FAIL maxit_clear got q=%0d err=%b cyc=%0d want 3 0 6", quotient8, err8, dc); end
   endtask

   task automatic test_mid_reset;
      logic [31:0] snap;
      @(posedge CLK); #1;
      a_in = 32'd100; b_in = 32'hFFFF_FFFD; start = 1'b1;
      @(posedge CLK); #1; start = 1'b0;
      repeat (4) begin @(posedge CLK); #1; end
      n_checks++; if (quotient !== 32'd3 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre got q=%0d busy=%b want 3 1", quotient, busy); end
      #1; RST = 1'b1; #1;
      n_checks++; if ({s, we, busy, done, quotient} !== 36'd0) begin n_fail++; $display("FAIL rst_async got s=%b we=%b busy=%b q=%0d want all 0", s, we, busy, quotient); end
      snap = temp;
      repeat (2) begin @(posedge CLK); #1; end
      n_checks++; if (temp !== snap) begin n_fail++; $display("FAIL rst_nowrite got %0d want %0d", temp, snap); end
      RST = 1'b0;
      begin
         int dc; logic [63:0] wb;
         launch(1'b0, 32'd100, 32'hFFFF_FFFD, dc, wb);
         n_checks++; if (dc !== 36 || quotient !== 32'd33 || temp !== 32'd1 || err !== 1'b0) begin n_fail++; $display("FAIL rst_rerun got cyc=%0d q=%0d rem=%0d err=%b want 36 33 1 0", dc, quotient, temp, err); end
      end
   endtask

   task automatic test_back_to_back;
      int ndone, dcyc;
      ndone = 0; dcyc = 0;
      @(posedge CLK); #1;
      a_in = 32'd17; b_in = 32'hFFFF_FFFB; start = 1'b1;
      @(posedge CLK); #1;
      for (int c = 1; c <= 15; c++) begin
         start = (c == 3 || c == 6);
         if (done) begin ndone++; dcyc = c; end
         @(posedge CLK); #1;
      end
      start = 1'b0;
      n_checks++; if (ndone !== 1 || dcyc !== 6) begin n_fail++; $display("FAIL b2b_done got n=%0d cyc=%0d want 1 6", ndone, dcyc); end
      n_checks++; if (quotient !== 32'd3) begin n_fail++; $display("FAIL b2b_q got %0d want 3", quotient); end
   endtask

   task automatic test_held_start;
      logic b7, b8v; int dc2;
      b7 = 1'bx; b8v = 1'bx; dc2 = 0;
      @(posedge CLK); #1;
      start = 1'b1;
      @(posedge CLK); #1;
      for (int c = 1; c <= 20; c++) begin
         if (c == 7) b7 = busy;
         if (c == 8) begin b8v = busy; start = 1'b0; end
         if (c > 7 && done) begin dc2 = c; break; end
         @(posedge CLK); #1;
      end
      n_checks++; if (b7 !== 1'b0 || b8v !== 1'b1) begin n_fail++; $display("FAIL held_relaunch got busy7=%b busy8=%b want 0 1", b7, b8v); end
      n_checks++; if (dc2 !== 13 || quotient !== 32'd3) begin n_fail++; $display("FAIL held_second got cyc=%0d q=%0d want 13 3", dc2, quotient); end
   endtask

`ifdef MY2_DIV_ZERO_DETECT_EN
   task automatic test_zero_detect;
      int dc; logic [63:0] wb;
      b_zero = 1'b1;
      launch(1'b0, 32'd9, 32'd0, dc, wb);
      b_zero = 1'b0;
      n_checks++; if (dc !== 1 || wb !== 64'h0) begin n_fail++; $display("FAIL zdet_timing got cyc=%0d we=%h want 1 0", dc, wb); end
      n_checks++; if (err !== 1'b1 || quotient !== 32'd0) begin n_fail++; $display("FAIL zdet_res got err=%b q=%0d want 1 0", err, quotient); end
   endtask
`endif

   initial begin
      test_reset();
      test_div_basic();
      test_exact();
      test_small_dividend();
      test_max_iter();
      test_mid_reset();
      test_back_to_back();
      test_held_start();
`ifdef MY2_DIV_ZERO_DETECT_EN
      test_zero_detect();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
